leg_fetch_unit: RTL

Instruction fetch stage for the LEG single-cycle/multi-cycle datapath. Owns the fetch program counter, issues word reads to the synchronous instruction ROM and buffers returned instructions in a small queue. It hands them to the control unit through a valid/ready handshake; the control unit's `fetch` strobe is the ready. It also absorbs branch redirects by flushing the queue and any in-flight ROM read.

---
 rtl/leg_pkg.sv | 19 +
 rtl/leg_fetch_queue.sv | 70 +++++++
 rtl/leg_fetch_unit.sv | 100 ++++++++++
 3 files changed

// File: rtl/leg_pkg.sv
// Shared types for the LEG fetch stage: instruction width, queue entry layout
// and the fetch sequencer states.
package leg_pkg;

  localparam int INSN_W = 32;
  localparam int PC_W   = 32;

  typedef struct packed {
    logic [INSN_W-1:0] insn;
    logic [PC_W-1:0]   pc;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/leg_fetch_queue.sv
// Circular instruction queue; the head is held in its own register so that it
// keeps its last value when the queue runs empty or is flushed.
module leg_fetch_queue import leg_pkg::*; #(
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  fetch_entry_t       push_entry,
  input  logic               pop,
  input  logic               flush,
  output logic [CNT_W-1:0]   count,
  output fetch_entry_t       head
);

  localparam int PTR_W = $clog2(DEPTH);

  fetch_entry_t            mem_q [DEPTH];
  fetch_entry_t            mem_d [DEPTH];
  logic [PTR_W-1:0]        rd_q, rd_d, wr_q, wr_d;
  logic [CNT_W-1:0]        count_q, count_d;
  fetch_entry_t            head_q, head_d;
  logic                    push_eff;

  always_comb begin
    push_eff = push && !flush;
    rd_d     = rd_q;
    wr_d     = wr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (pop) begin
      rd_d    = rd_q + 1'b1;
      count_d = count_d - 1'b1;
    end
    if (flush) begin
      rd_d    = '0;
      wr_d    = '0;
      count_d = '0;
    end else if (push) begin
      mem_d[wr_q] = push_entry;
      wr_d        = wr_q + 1'b1;
      count_d     = count_d + 1'b1;
    end
    // A push landing in the new head slot bypasses the array.
    head_d = head_q;
    if (count_d != '0)
      head_d = (push_eff && (wr_q == rd_d)) ? push_entry : mem_q[rd_d];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q   <= '{default: '0};
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
      head_q  <= '0;
    end else begin
      mem_q   <= mem_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
      head_q  <= head_d;
    end
  end

  assign count = count_q;
  assign head  = head_q;

endmodule

// File: rtl/leg_fetch_unit.sv
// Fetch stage: owns the fetch PC, issues ROM word reads, tracks the single
// in-flight read and feeds returned words into the instruction queue.
//
//   state | meaning
//   IDLE  | just out of reset, nothing issued yet
//   RUN   | issuing reads while the queue has room
//   HALT  | no new reads; in-flight read and queue still drain
module leg_fetch_unit import leg_pkg::*; #(
  parameter int              PC_W     = leg_pkg::PC_W,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              ROM_AW   = 10,
  parameter int              QDEPTH   = 2
) (
  input  logic              CLOCK_50,
  input  logic              reset_n,
  output logic              rom_en,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [31:0]       rom_data,
  output logic [31:0]       insn,
  output logic [PC_W-1:0]   insn_pc,
  output logic              insn_valid,
  input  logic              insn_ready,
  input  logic              redirect,
  input  logic [PC_W-1:0]   redirect_pc,
  input  logic              halt
);

  localparam int CNT_W = $clog2(QDEPTH + 1);

  fetch_state_e     state_q, state_d;
  logic [PC_W-1:0]  fpc_q, fpc_d;
  logic [PC_W-1:0]  inflight_pc_q, inflight_pc_d;
  logic             inflight_q, inflight_d;
  logic             pop, push, room;
  logic [CNT_W-1:0] q_count;
  fetch_entry_t     q_head, push_entry;

  assign pop = insn_valid && insn_ready;

  always_comb begin
    // Room counts the in-flight word and frees the slot popped this cycle.
    room       = (int'(q_count) + int'(inflight_q) - int'(pop)) < QDEPTH;
    rom_en     = (state_q == RUN) && !redirect && room;
    push       = inflight_q && !redirect;
    push_entry = '{insn: rom_data, pc: inflight_pc_q};

    state_d = state_q;
    case (state_q)
      IDLE:    state_d = RUN;
      RUN:     if (halt) state_d = HALT;
      HALT:    if (!halt) state_d = RUN;
      default: state_d = IDLE;
    endcase

    fpc_d         = fpc_q;
    inflight_d    = rom_en;
    inflight_pc_d = inflight_pc_q;
    if (redirect) begin
      fpc_d = {redirect_pc[PC_W-1:2], 2'b00};
    end else if (rom_en) begin
      fpc_d         = fpc_q + PC_W'(4);
      inflight_pc_d = fpc_q;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      fpc_q         <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      state_q       <= state_d;
      fpc_q         <= fpc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  assign rom_addr = fpc_q[ROM_AW+1:2];

  leg_fetch_queue #(
    .DEPTH (QDEPTH),
    .CNT_W (CNT_W)
  ) u_queue (
    .clk        (CLOCK_50),
    .rst_n      (reset_n),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (redirect),
    .count      (q_count),
    .head       (q_head)
  );

  assign insn_valid = (q_count != '0);
  assign insn       = q_head.insn;
  assign insn_pc    = q_head.pc;

endmodule
